// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: repeatedly feeds a board to an external single-row eliminator until no full row remains.
// Optional macro LINE_CLEAR_SCORE_EN enables the score increment output; otherwise score_add is tied to zero.
module line_clear_ctrl (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [0:199]   board_in,
    output logic [0:199]   elim_static,
    input  logic           elim_eliminated,
    input  logic [0:199]   elim_new_static,
    output logic [0:199]   board_out,
    output logic           busy,
    output logic           done,
    output logic [4:0]     rows_cleared,
    output logic [10:0]    score_add,
    output logic [15:0]    lines_total
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // The board has 20 rows; the guard allows 21 SCAN cycles (iteration index 0..20).
    localparam logic [4:0] MAX_ROWS   = 5'd20;
    localparam logic [4:0] GUARD_LAST = 5'd20;

    state_t        state;
    state_t        state_nxt;

    logic [0:199]  board_reg;
    logic [4:0]    row_cnt;
    logic [4:0]    iter_cnt;

    logic          load_start;
    logic          load_elim;
    logic          finish;

    logic [0:199]  board_final;
    logic [4:0]    row_cnt_inc;
    logic [4:0]    rows_final;
    logic [16:0]   lines_sum;
    logic [15:0]   lines_sat;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        load_elim  = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    state_nxt  = SCAN;
                end
            end
            SCAN: begin
                busy      = 1'b1;
                load_elim = elim_eliminated;
                // Leave when nothing more was removed, or when the iteration guard expires.
                if (!elim_eliminated || (iter_cnt == GUARD_LAST)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath values for this SCAN cycle
    // ------------------------------------------------------------------
    always_comb begin
        row_cnt_inc = (row_cnt == MAX_ROWS) ? row_cnt : (row_cnt + 5'd1);
        rows_final  = load_elim ? row_cnt_inc : row_cnt;
        board_final = load_elim ? elim_new_static : board_reg;
        lines_sum   = {1'b0, lines_total} + {12'd0, rows_final};
        lines_sat   = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
    end

    assign elim_static = board_reg;

    // ------------------------------------------------------------------
    // Working board, counters and result registers
    // ------------------------------------------------------------------
    // NOTE: the wide board register is reset too, since elim_static must read zero while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            board_reg    <= '0;
            row_cnt      <= '0;
            iter_cnt     <= '0;
            board_out    <= '0;
            rows_cleared <= '0;
            lines_total  <= '0;
        end else begin
            if (load_start) begin
                board_reg <= board_in;
                row_cnt   <= '0;
                iter_cnt  <= '0;
            end else if (state == SCAN) begin
                board_reg <= board_final;
                row_cnt   <= rows_final;
                if (iter_cnt != GUARD_LAST) begin
                    iter_cnt <= iter_cnt + 5'd1;
                end
            end

            // Results are captured on the edge entering DONE so they are valid with the done pulse.
            if (finish) begin
                board_out    <= board_final;
                rows_cleared <= rows_final;
                lines_total  <= lines_sat;
            end
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [10:0] score_reg;

    function automatic logic [10:0] score_for(input logic [4:0] rows);
        logic [10:0] pts;
        case (rows)
            5'd0:    pts = 11'd0;
            5'd1:    pts = 11'd40;
            5'd2:    pts = 11'd100;
            5'd3:    pts = 11'd300;
            default: pts = 11'd1200;
        endcase
        return pts;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            score_reg <= '0;
        end else if (finish) begin
            score_reg <= score_for(rows_final);
        end
    end

    assign score_add = score_reg;
`else
    assign score_add = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a behavioural single-row eliminator and a stuck-high stub mode.
module tb_line_clear_ctrl;

    logic           clk;
    logic           rst;
    logic           start;
    logic [0:199]   board_in;
    logic [0:199]   elim_static;
    logic           elim_eliminated;
    logic [0:199]   elim_new_static;
    logic [0:199]   board_out;
    logic           busy;
    logic           done;
    logic [4:0]     rows_cleared;
    logic [10:0]    score_add;
    logic [15:0]    lines_total;

    logic           stub_mode;
    int             n_checks;
    int             n_fail;

    line_clear_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .board_in        (board_in),
        .elim_static     (elim_static),
        .elim_eliminated (elim_eliminated),
        .elim_new_static (elim_new_static),
        .board_out       (board_out),
        .busy            (busy),
        .done            (done),
        .rows_cleared    (rows_cleared),
        .score_add       (score_add),
        .lines_total     (lines_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Eliminator model: removes the bottom-most full row and shifts everything above it down by one.
    function automatic int bottom_full(input logic [0:199] b);
        int found;
        found = -1;
        for (int r = 0; r < 20; r++) begin
            if (&b[r*10 +: 10]) found = r;
        end
        return found;
    endfunction

    function automatic logic [0:199] elim_model(input logic [0:199] b);
        logic [0:199] res;
        int fr;
        res = b;
        fr  = bottom_full(b);
        if (fr >= 0) begin
            for (int r = fr; r >= 1; r--) res[r*10 +: 10] = b[(r-1)*10 +: 10];
            res[0 +: 10] = '0;
        end
        return res;
    endfunction

    always_comb begin
        if (stub_mode) begin
            elim_eliminated = 1'b1;
            elim_new_static = elim_static;
        end else begin
            elim_eliminated = (bottom_full(elim_static) >= 0);
            elim_new_static = elim_model(elim_static);
        end
    end

    function automatic logic [10:0] exp_score(input int rows);
`ifdef LINE_CLEAR_SCORE_EN
        case (rows)
            0:       return 11'd0;
            1:       return 11'd40;
            2:       return 11'd100;
            3:       return 11'd300;
            default: return 11'd1200;
        endcase
`else
        return 11'd0;
`endif
    endfunction

    // Pulse start for one cycle; returns at the negedge inside the first cycle after the sampling edge.
    task automatic start_op(input logic [0:199] b);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Cycle index relative to the start-sampling edge at which done was seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        logic [0:199] ones;
        ones     = '1;
        rst      = 1'b1;
        start    = 1'b0;
        board_in = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (board_out !== '0) begin n_fail++; $display("FAIL reset_board_out: got %h expected 0", board_out); end
        n_checks++; if (rows_cleared !== 5'd0) begin n_fail++; $display("FAIL reset_rows: got %0d expected 0", rows_cleared); end
        n_checks++; if (score_add !== 11'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score_add); end
        n_checks++; if (lines_total !== 16'd0) begin n_fail++; $display("FAIL reset_lines: got %0d expected 0", lines_total); end
        n_checks++; if (elim_static !== '0) begin n_fail++; $display("FAIL reset_elim_static: got %h expected 0", elim_static); end
        rst = 1'b0;
        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        board_in = ones;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_prio_busy: got %0b expected 0", busy); end
        n_checks++; if (elim_static !== '0) begin n_fail++; $display("FAIL rst_prio_board: got %h expected 0", elim_static); end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_empty;
        int cyc;
        start_op('0);
        wait_done(cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL empty_latency: got %0d expected 2", cyc); end
        n_checks++; if (rows_cleared !== 5'd0) begin n_fail++; $display("FAIL empty_rows: got %0d expected 0", rows_cleared); end
        n_checks++; if (board_out !== '0) begin n_fail++; $display("FAIL empty_board: got %h expected 0", board_out); end
        n_checks++; if (score_add !== 11'd0) begin n_fail++; $display("FAIL empty_score: got %0d expected 0", score_add); end
    endtask

    task automatic test_two_rows;
        logic [0:199] b;
        logic [0:199] exp_b;
        int cyc;
        b = '0;
        b[180 +: 20] = '1;
        b[170] = 1'b1;
        b[0]   = 1'b1;
        exp_b = '0;
        exp_b[20]  = 1'b1;
        exp_b[190] = 1'b1;
        start_op(b);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL two_busy: got %0b expected 1", busy); end
        wait_done(cyc);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL two_latency: got %0d expected 4", cyc); end
        n_checks++; if (rows_cleared !== 5'd2) begin n_fail++; $display("FAIL two_rows: got %0d expected 2", rows_cleared); end
        n_checks++; if (board_out !== exp_b) begin n_fail++; $display("FAIL two_board: got %h expected %h", board_out, exp_b); end
        n_checks++; if (score_add !== exp_score(2)) begin n_fail++; $display("FAIL two_score: got %0d expected %0d", score_add, exp_score(2)); end
        n_checks++; if (lines_total !== 16'd2) begin n_fail++; $display("FAIL two_lines: got %0d expected 2", lines_total); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL two_done_width: got done=%0b busy=%0b expected 0 0", done, busy); end
    endtask

    task automatic test_four_rows;
        logic [0:199] b;
        logic [0:199] exp_b;
        int cyc;
        b = '0;
        b[160 +: 40] = '1;
        b[0] = 1'b1;
        exp_b = '0;
        exp_b[40] = 1'b1;
        start_op(b);
        wait_done(cyc);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL four_latency: got %0d expected 6", cyc); end
        n_checks++; if (rows_cleared !== 5'd4) begin n_fail++; $display("FAIL four_rows: got %0d expected 4", rows_cleared); end
        n_checks++; if (board_out !== exp_b) begin n_fail++; $display("FAIL four_board: got %h expected %h", board_out, exp_b); end
        n_checks++; if (score_add !== exp_score(4)) begin n_fail++; $display("FAIL four_score: got %0d expected %0d", score_add, exp_score(4)); end
        n_checks++; if (lines_total !== 16'd6) begin n_fail++; $display("FAIL four_lines: got %0d expected 6", lines_total); end
    endtask

    task automatic test_ignore_start;
        logic [0:199] b;
        logic [0:199] exp_b;
        logic [0:199] ones;
        logic         extra_done;
        ones = '1;
        b = '0;
        b[190 +: 10] = '1;
        b[5] = 1'b1;
        exp_b = '0;
        exp_b[15] = 1'b1;
        start_op(b);
        @(negedge clk);
        // Second SCAN cycle: new request with a different board, held through the DONE cycle.
        board_in = ones;
        start    = 1'b1;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %0b expected 1", done); end
        n_checks++; if (rows_cleared !== 5'd1) begin n_fail++; $display("FAIL ign_rows: got %0d expected 1", rows_cleared); end
        n_checks++; if (board_out !== exp_b) begin n_fail++; $display("FAIL ign_board: got %h expected %h", board_out, exp_b); end
        n_checks++; if (score_add !== exp_score(1)) begin n_fail++; $display("FAIL ign_score: got %0d expected %0d", score_add, exp_score(1)); end
        n_checks++; if (lines_total !== 16'd7) begin n_fail++; $display("FAIL ign_lines: got %0d expected 7", lines_total); end
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_after: got %0b expected 0", busy); end
        extra_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) extra_done = 1'b1;
        end
        n_checks++; if (extra_done !== 1'b0) begin n_fail++; $display("FAIL ign_second_op: got %0b expected 0", extra_done); end
        n_checks++; if (board_out !== exp_b) begin n_fail++; $display("FAIL ign_board_hold: got %h expected %h", board_out, exp_b); end
    endtask

    task automatic test_reset_mid_scan;
        logic [0:199] b;
        logic         seen;
        b = '0;
        b[170 +: 30] = '1;
        start_op(b);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %0b expected 0", done); end
        n_checks++; if (board_out !== '0) begin n_fail++; $display("FAIL mid_rst_board_out: got %h expected 0", board_out); end
        n_checks++; if (rows_cleared !== 5'd0) begin n_fail++; $display("FAIL mid_rst_rows: got %0d expected 0", rows_cleared); end
        n_checks++; if (score_add !== 11'd0) begin n_fail++; $display("FAIL mid_rst_score: got %0d expected 0", score_add); end
        n_checks++; if (lines_total !== 16'd0) begin n_fail++; $display("FAIL mid_rst_lines: got %0d expected 0", lines_total); end
        n_checks++; if (elim_static !== '0) begin n_fail++; $display("FAIL mid_rst_elim: got %h expected 0", elim_static); end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_done: got %0b expected 0", seen); end
    endtask

    task automatic test_guard;
        logic [0:199] b;
        int cyc;
        b = '0;
        b[0] = 1'b1;
        @(negedge clk);
        stub_mode = 1'b1;
        start_op(b);
        wait_done(cyc);
        n_checks++; if (cyc !== 22) begin n_fail++; $display("FAIL guard_latency: got %0d expected 22", cyc); end
        n_checks++; if (rows_cleared !== 5'd20) begin n_fail++; $display("FAIL guard_rows: got %0d expected 20", rows_cleared); end
        n_checks++; if (board_out !== b) begin n_fail++; $display("FAIL guard_board: got %h expected %h", board_out, b); end
        n_checks++; if (score_add !== exp_score(20)) begin n_fail++; $display("FAIL guard_score: got %0d expected %0d", score_add, exp_score(20)); end
        n_checks++; if (lines_total !== 16'd20) begin n_fail++; $display("FAIL guard_lines: got %0d expected 20", lines_total); end
        @(negedge clk);
        stub_mode = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL guard_idle: got %0b expected 0", busy); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        stub_mode = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        board_in  = '0;
        test_reset();
        test_empty();
        test_two_rows();
        test_four_rows();
        test_ignore_start();
        test_reset_mid_scan();
        test_guard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_clear_ctrl.md
LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle request to clear full rows of board_in.
REQ-004 SHALL have port board_in  input  [0:199]  landed-piece static board, row-major, 20 rows x 10 cols, index 0 = top-left.
REQ-005 SHALL have port elim_static  output  [0:199]  board presented to the row eliminator.
REQ-006 SHALL have port elim_eliminated  input  1  eliminator flag: one full row removed.
REQ-007 SHALL have port elim_new_static  input  [0:199]  eliminator result board.
REQ-008 SHALL have port board_out  output  [0:199]  cleared board, valid when done=1, held until next accepted start.
REQ-009 SHALL have port busy  output  1  high while not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rows_cleared  output  [4:0]  rows removed by last operation, 0..20.
REQ-012 SHALL have port score_add  output  [10:0]  score increment of last operation.
REQ-013 SHALL have port lines_total  output  [15:0]  saturating count of all rows cleared since reset.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE, held in a registered state variable.
REQ-015 In IDLE, start=1 SHALL latch board_in into the internal board register, clear the row counter and iteration counter, and enter SCAN.
REQ-016 start SHALL be ignored while busy=1; no queuing.
REQ-017 elim_static SHALL always equal the internal board register; eliminator outputs are combinational w.r.t. elim_static, used in the same cycle.
REQ-018 In SCAN with elim_eliminated=1, the board register SHALL load elim_new_static and the row counter SHALL increment.
REQ-019 In SCAN with elim_eliminated=0, the FSM SHALL enter DONE with board unchanged.
REQ-020 An iteration guard SHALL force SCAN->DONE after 21 SCAN cycles, regardless of elim_eliminated.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle; board_out, rows_cleared, score_add update that cycle; lines_total adds rows_cleared, saturating at 16'hFFFF; the next state is IDLE.
REQ-022 Latency: start sampled at edge T with k full rows -> done high in cycle T+k+2 (k+1 SCAN cycles, 1 DONE cycle).
REQ-023 busy SHALL be 1 in SCAN and DONE, 0 in IDLE; start in the DONE cycle SHALL be ignored.
REQ-024 A board with no full rows SHALL complete in 2 cycles with rows_cleared=0 and board_out=board_in.

Reset
REQ-025 rst=1 at any edge, including mid-SCAN, SHALL force IDLE, zero all internal registers, and make every output 0 (board_out, rows_cleared, score_add, lines_total, busy, done, elim_static).
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro LINE_CLEAR_SCORE_EN defined: score_add SHALL be 0/40/100/300/1200 for 0/1/2/3/>=4 rows cleared.
REQ-028 Macro LINE_CLEAR_SCORE_EN undefined: score_add SHALL be tied to 0 with no scoring logic; all other behaviour is unchanged.

Verification
REQ-029 Empty board, start at T -> done at T+2, rows_cleared=0, board_out=0, score_add=0.
REQ-030 Rows 18 and 19 full, start -> done at T+4, rows_cleared=2, full rows removed, rows above shifted down by 2, score_add=100 (SCORE_EN).
REQ-031 Rows 16..19 full plus bit 0 set -> rows_cleared=4, score_add=1200, bit 40 set in board_out, lines_total += 4.
REQ-032 start pulsed again in 2nd SCAN cycle -> ignored; single done; results reflect only the first board.
REQ-033 rst asserted in 2nd SCAN cycle of a 3-row clear -> next cycle busy=0, all outputs 0, no done pulse.
REQ-034 Eliminator stub holding elim_eliminated=1 -> done at T+22, rows_cleared=21 clipped to 20 by guard semantics (counter saturates at 20).
